// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type and helper functions for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  function automatic int kp_code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int kp_popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/kp_stable_cnt.sv
// rtl/kp_stable_cnt.sv - counts consecutive cycles where din equals ref_val, saturating at TARGET
module kp_stable_cnt #(
  parameter int W      = 4,
  parameter int TARGET = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] din,
  input  logic [W-1:0] ref_val,
  output logic         match,
  output logic         done
);

  localparam int CNTW = (TARGET > 1) ? $clog2(TARGET) : 1;

  logic [CNTW-1:0] cnt;

  assign match = (din == ref_val);
  // done marks the TARGET-th consecutive match, so the owner acts in that same cycle
  assign done  = match && (cnt == CNTW'(TARGET - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !match) begin
      cnt <= '0;
    end else if (cnt != CNTW'(TARGET - 1)) begin
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with debounce, multi-key rejection and auto-repeat
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 3,
  parameter int DWELL         = 16,
  parameter int DB_CYCLES     = 1000,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ROWS-1:0]                    row,
  output logic [COLS-1:0]                    col,
  output logic [kp_code_w(ROWS, COLS)-1:0]   key_code,
  output logic                               key_valid,
  output logic                               key_held,
  output logic                               multi_err
);

  localparam int CW  = kp_code_w(ROWS, COLS);
  localparam int CIW = $clog2(COLS);
  localparam int DWW = $clog2(DWELL);
  localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  kp_state_t       state;
  logic [CIW-1:0]  col_idx;
  logic [CIW-1:0]  col_next;
  logic [DWW-1:0]  dwell_cnt;
  logic [RPW-1:0]  rep_cnt;
  logic [ROWS-1:0] rs_meta;
  logic [ROWS-1:0] rs;
  logic [ROWS-1:0] snap;
  logic [ROWS-1:0] cmp_ref;
  logic            st_clear;
  logic            st_match;
  logic            st_done;
  int              row_idx;

  assign col      = COLS'(1) << col_idx;
  assign col_next = (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);

  // One counter serves both press debounce (against snap) and release detection (against 0)
  always_comb begin
    cmp_ref  = (state == DEBOUNCE) ? snap : '0;
    st_clear = (state == SCAN) || ((state == DEBOUNCE) && st_done);
    row_idx  = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (snap[i]) row_idx = i;
    end
  end

  kp_stable_cnt #(
    .W      (ROWS),
    .TARGET (DB_CYCLES)
  ) u_stable (
    .clk     (clk),
    .reset   (reset),
    .clear   (st_clear),
    .din     (rs),
    .ref_val (cmp_ref),
    .match   (st_match),
    .done    (st_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta <= '0;
      rs      <= '0;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      dwell_cnt <= '0;
      rep_cnt   <= '0;
      snap      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell_cnt == DWW'(DWELL - 1)) begin
            dwell_cnt <= '0;
            if (rs != '0) begin
              snap  <= rs;
              state <= DEBOUNCE;
            end else begin
              col_idx <= col_next;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWW'(1);
          end
        end
        DEBOUNCE: begin
          if (!st_match) begin
            dwell_cnt <= '0;
            state     <= SCAN;
          end else if (st_done) begin
            if (kp_popcount(32'(snap)) == 1) begin
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              key_code  <= CW'(int'(col_idx) * ROWS + row_idx);
              rep_cnt   <= '0;
              state     <= HELD;
            end else begin
              multi_err <= 1'b1;
              state     <= RELEASE;
            end
          end
        end
        HELD: begin
          // A completed release takes priority over a coincident repeat
          if (st_done) begin
            key_held  <= 1'b0;
            col_idx   <= col_next;
            dwell_cnt <= '0;
            state     <= SCAN;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_cnt == RPW'(REPEAT_CYCLES - 1)) begin
              rep_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RPW'(1);
            end
          end
        end
        RELEASE: begin
          if (st_done) begin
            col_idx   <= col_next;
            dwell_cnt <= '0;
            state     <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner with column drive, row synchronisation, counter-based debounce, single-key decode, multi-key rejection and optional auto-repeat. It drives one-hot columns, samples active-high rows, and emits a one-cycle `key_valid` strobe with a linear key code. It sits between the keypad pads and the vending-control FSM, and generalises the fixed 3x4 mapper to any matrix size.

## Interface
- `ROWS`, 4, number of row inputs (≥1)
- `COLS`, 3, number of column outputs (≥2)
- `DWELL`, 16, clk cycles each column is driven before rows are sampled (≥3)
- `DB_CYCLES`, 1000, consecutive identical samples required for press/release stability (≥1)
- `REPEAT_CYCLES`, 0, auto-repeat period while held; 0 disables repeat
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `row`  in  ROWS  raw row pads, active-high, asynchronous to clk
- `col`  out  COLS  one-hot column drive
- `key_code`  out  CW = $clog2(ROWS*COLS)  code = col_idx*ROWS + row_idx, held until next strobe
- `key_valid`  out  1  one-cycle strobe, new press or repeat
- `key_held`  out  1  high from accepted press until debounced release
- `multi_err`  out  1  one-cycle strobe, more than one row stable-high at debounce completion

## Operation
- `row` passes through a 2-flop synchroniser; all logic uses synchronised `rs`.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: `col` one-hot at `col_idx`; dwell counter counts 0..DWELL-1. On the last dwell cycle: if `rs`≠0, latch `rs` into `snap`, clear stability counter, go to DEBOUNCE with the column frozen; else advance `col_idx` (COLS-1 wraps to 0) and restart dwell.
- DEBOUNCE: each cycle, if `rs`==`snap`, increment the counter; else return to SCAN at the same column with dwell restarted. When the counter reaches DB_CYCLES:
  - popcount(`snap`)==1: strobe `key_valid`, load `key_code`, set `key_held`, go to HELD.
  - popcount>1: strobe `multi_err`, go to RELEASE; `key_code` is unchanged.
- HELD: `rs`==0 for DB_CYCLES consecutive cycles (counter clears on any nonzero) → clear `key_held`, advance `col_idx`, go to SCAN. If REPEAT_CYCLES>0, a repeat counter strobes `key_valid` (same code) every REPEAT_CYCLES cycles while in HELD; the first repeat comes REPEAT_CYCLES cycles after the press strobe.
- RELEASE: same release rule as HELD, with no `key_held` and no repeats.
- Reset (asynchronous, any state): state SCAN, `col_idx`=0, `col`=1, `key_code`=0, `key_valid`=0, `key_held`=0, `multi_err`=0, all counters 0, synchroniser flops 0. Reset mid-press discards the press; no strobe is emitted afterwards until a full new debounce completes.
- `key_valid` and `multi_err` are never high in the same cycle.

## Timing
- Press latency: a row edge stable from dwell start → `key_valid` at 2 (sync) + remaining dwell + DB_CYCLES cycles; registered outputs, no combinational input-to-output path.
- Full idle scan period: COLS*DWELL cycles.
- Minimum gap between two distinct press strobes: ≥2*DB_CYCLES + DWELL.
- A repeat strobe and a release completion in the same cycle: release wins, no strobe.
- A glitch shorter than DB_CYCLES produces no output and restarts the dwell.

## Structure
- Shared package `keypad_pkg`: state enum `kp_state_t` {SCAN, DEBOUNCE, HELD, RELEASE}, function `kp_code_w(rows, cols)` and the popcount function.
- One sub-module, `kp_stable_cnt`: compares an input against a reference, saturating up-counter to a parameter, `done` output and clear input. It is instantiated once and shared between DEBOUNCE and the release detection.
- Everything else is the top-level FSM and column/dwell counters.

## Test plan
- Reset release with no key pressed, DWELL=4, COLS=3 → `col` sequences 001,010,100,001 every 4 cycles; all other outputs stay 0.
- Default params, hold row[1] only while col[2] is driven → single `key_valid`, `key_code`=9, `key_held`=1. On release, `key_held` falls DB_CYCLES cycles after `rs` goes 0, and scanning resumes at column 0.
- Bounce row[0] high/low every 10 cycles for 500 cycles, DB_CYCLES=100 → no strobes. Then hold it steady → exactly one `key_valid`, `key_code`=0.
- Rows 0 and 2 held together in column 1 → one `multi_err`, no `key_valid`, `key_code` retains its prior value, `key_held`=0.
- REPEAT_CYCLES=50, key held 260 cycles past acceptance → press strobe plus 5 repeat strobes spaced exactly 50 cycles apart, all with the same code.
- Assert `reset` during DEBOUNCE and again during HELD → outputs return to reset values immediately (asynchronously); no strobe until a fresh full debounce.
